// File: rtl/bus_demux2.sv
// Bridges one CPU data-side master onto a memory slave (S0) or a peripheral slave (S1).
// Define DEMUX_TIMEOUT_EN to enable the BUSY watchdog, which errors out after TO_CYCLES without an ack.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready for a master request; m_ready_o = 1
//   S_BUSY | request forwarded to the selected slave, waiting for its ack
module bus_demux2 #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  S1_BASE   = ADDR_W'(32'hFFFF_F000),
    parameter logic [ADDR_W-1:0]  S1_MASK   = ADDR_W'(32'hFFFF_F000),
    parameter int                 TO_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req_i,
    input  logic              m_we_i,
    input  logic [ADDR_W-1:0] m_addr_i,
    input  logic [DATA_W-1:0] m_wdata_i,
    output logic              m_ready_o,
    output logic              m_done_o,
    output logic [DATA_W-1:0] m_rdata_o,
    output logic              m_err_o,
    output logic              s0_req_o,
    output logic              s0_we_o,
    output logic [ADDR_W-1:0] s0_addr_o,
    output logic [DATA_W-1:0] s0_wdata_o,
    input  logic              s0_ack_i,
    input  logic [DATA_W-1:0] s0_rdata_i,
    output logic              s1_req_o,
    output logic              s1_we_o,
    output logic [ADDR_W-1:0] s1_addr_o,
    output logic [DATA_W-1:0] s1_wdata_o,
    input  logic              s1_ack_i,
    input  logic [DATA_W-1:0] s1_rdata_i
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              ack_sel;
    logic [DATA_W-1:0] rdata_sel;

`ifdef DEMUX_TIMEOUT_EN
    localparam int          CNT_W      = $clog2(TO_CYCLES + 1);
    localparam logic [31:0] TO_PATTERN = 32'hDEAD_BEEF;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    localparam int unused_to_cycles = TO_CYCLES;
`endif

    // Only the selected slave's ack and data are ever looked at.
    assign ack_sel   = sel_q ? s1_ack_i   : s0_ack_i;
    assign rdata_sel = sel_q ? s1_rdata_i : s0_rdata_i;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
`ifdef DEMUX_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (m_req_i) begin
                    state_d = S_BUSY;
                    sel_d   = ((m_addr_i & S1_MASK) == S1_BASE);
                    we_d    = m_we_i;
                    addr_d  = m_addr_i;
                    wdata_d = m_wdata_i;
`ifdef DEMUX_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUSY: begin
                if (ack_sel) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = rdata_sel;
                    end
`ifdef DEMUX_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TO_CYCLES - 1)) begin
                    // Expiry edge: an ack on this same edge is handled by the branch above.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(TO_PATTERN);
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

`ifdef DEMUX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign m_err_o = err_q;
`else
    assign m_err_o = 1'b0;
`endif

    // Slave req is decoded from registered state so reset removes it asynchronously.
    assign m_ready_o  = (state_q == S_IDLE);
    assign m_done_o   = done_q;
    assign m_rdata_o  = rdata_q;

    assign s0_req_o   = (state_q == S_BUSY) && !sel_q;
    assign s1_req_o   = (state_q == S_BUSY) &&  sel_q;
    assign s0_we_o    = we_q;
    assign s1_we_o    = we_q;
    assign s0_addr_o  = addr_q;
    assign s1_addr_o  = addr_q;
    assign s0_wdata_o = wdata_q;
    assign s1_wdata_o = wdata_q;

endmodule

// File: tb/tb_bus_demux2.sv
// Self-checking bench for bus_demux2 using directed scenarios plus randomized transactions.
// The reference model decodes S1 as the top 4 KiB of the address space and tracks the last read value.
module tb_bus_demux2;

    logic        clk;
    logic        rst_n;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_ready, m_done, m_err;
    logic [31:0] m_rdata;
    logic        s0_req, s0_we, s0_ack;
    logic [31:0] s0_addr, s0_wdata, s0_rdata;
    logic        s1_req, s1_we, s1_ack;
    logic [31:0] s1_addr, s1_wdata, s1_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata = 32'h0;

    bus_demux2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_req_i    (m_req),
        .m_we_i     (m_we),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_ready_o  (m_ready),
        .m_done_o   (m_done),
        .m_rdata_o  (m_rdata),
        .m_err_o    (m_err),
        .s0_req_o   (s0_req),
        .s0_we_o    (s0_we),
        .s0_addr_o  (s0_addr),
        .s0_wdata_o (s0_wdata),
        .s0_ack_i   (s0_ack),
        .s0_rdata_i (s0_rdata),
        .s1_req_o   (s1_req),
        .s1_we_o    (s1_we),
        .s1_addr_o  (s1_addr),
        .s1_wdata_o (s1_wdata),
        .s1_ack_i   (s1_ack),
        .s1_rdata_i (s1_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in the current cycle and plays the slave side. Returns in the m_done cycle.
    // lat counts edges from acceptance to the edge that raised m_done; -1 if it never came.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_lat, input logic [31:0] ack_data, input int stray_at,
                           output int lat, output logic [31:0] rd, output logic err,
                           output int viol, output logic rdy, output logic [31:0] seen_addr,
                           output logic [31:0] seen_wdata, output logic seen_we);
        logic tgt;
        tgt     = (addr >= 32'hFFFF_F000);
        rdy     = m_ready;
        m_req   = 1'b1;
        m_we    = we;
        m_addr  = addr;
        m_wdata = wdata;
        step();
        m_req   = 1'b0;
        m_we    = $urandom_range(1);
        m_addr  = $urandom;
        m_wdata = $urandom;
        seen_addr  = tgt ? s1_addr  : s0_addr;
        seen_wdata = tgt ? s1_wdata : s0_wdata;
        seen_we    = tgt ? s1_we    : s0_we;
        lat  = -1;
        viol = 0;
        rd   = 'x;
        err  = 1'bx;
        for (int c = 0; c < 100; c++) begin
            if (m_done === 1'b1) begin
                if (c == 0) viol++;
                else begin
                    lat = c;
                    rd  = m_rdata;
                    err = m_err;
                    break;
                end
            end
            if (m_ready !== 1'b0) viol++;
            if (tgt ? (s1_req !== 1'b1 || s0_req !== 1'b0)
                    : (s0_req !== 1'b1 || s1_req !== 1'b0)) viol++;
            s0_ack   = tgt ? (c == stray_at) : (c == ack_lat);
            s1_ack   = tgt ? (c == ack_lat)  : (c == stray_at);
            s0_rdata = (!tgt && c == ack_lat) ? ack_data : $urandom;
            s1_rdata = ( tgt && c == ack_lat) ? ack_data : $urandom;
            step();
            s0_ack = 1'b0;
            s1_ack = 1'b0;
        end
        if (lat >= 0 && (s0_req !== 1'b0 || s1_req !== 1'b0 || m_ready !== 1'b1)) viol++;
    endtask

    task automatic test_reset();
        m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        s0_ack = 0; s1_ack = 0; s0_rdata = 0; s1_rdata = 0;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({m_ready, m_done, m_err, s0_req, s1_req, s0_we, s1_we} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {m_ready, m_done, m_err, s0_req, s1_req, s0_we, s1_we});
        end
        n_checks++;
        if ({m_rdata, s0_addr, s1_wdata} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h want all zero", m_rdata, s0_addr, s1_wdata);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_s0();
        int lat, viol; logic [31:0] rd, sa, sw; logic err, rdy, swe;
        run_txn(1'b0, 32'h0000_0010, 32'h0, 2, 32'h1234_5678, -1, lat, rd, err, viol, rdy, sa, sw, swe);
        exp_rdata = 32'h1234_5678;
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL read_s0 ready: got %b want 1", rdy); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read_s0 latency: got %0d want 3", lat); end
        n_checks++; if (rd !== exp_rdata) begin n_fail++; $display("FAIL read_s0 rdata: got %h want %h", rd, exp_rdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL read_s0 err: got %b want 0", err); end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL read_s0 protocol: got %0d violations want 0", viol); end
        n_checks++; if (sa !== 32'h10 || swe !== 1'b0) begin n_fail++; $display("FAIL read_s0 bus: got addr %h we %b want 00000010 0", sa, swe); end
        step();
        n_checks++;
        if (m_done !== 1'b0 || m_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL read_s0 after: got done %b rdata %h want 0 %h", m_done, m_rdata, exp_rdata);
        end
    endtask

    task automatic test_write_s1();
        int lat, viol; logic [31:0] rd, sa, sw; logic err, rdy, swe;
        run_txn(1'b1, 32'hFFFF_F000, 32'hA5, 0, 32'hCAFE_0001, -1, lat, rd, err, viol, rdy, sa, sw, swe);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL write_s1 latency: got %0d want 1", lat); end
        n_checks++; if (swe !== 1'b1 || sw !== 32'hA5) begin n_fail++; $display("FAIL write_s1 bus: got we %b wdata %h want 1 000000a5", swe, sw); end
        n_checks++; if (rd !== exp_rdata) begin n_fail++; $display("FAIL write_s1 rdata: got %h want %h", rd, exp_rdata); end
        n_checks++; if (err !== 1'b0 || viol !== 0) begin n_fail++; $display("FAIL write_s1 status: got err %b viol %0d want 0 0", err, viol); end
        step();
    endtask

    task automatic test_back_to_back();
        int lat, viol; logic [31:0] rd, sa, sw; logic err, rdy, swe;
        run_txn(1'b0, 32'hFFFF_F004, 32'h0, 1, 32'h0BAD_F00D, -1, lat, rd, err, viol, rdy, sa, sw, swe);
        n_checks++; if (lat !== 2 || rd !== 32'h0BAD_F00D || viol !== 0) begin
            n_fail++; $display("FAIL b2b first: got lat %0d rdata %h viol %0d want 2 0badf00d 0", lat, rd, viol); end
        run_txn(1'b0, 32'h0000_2000, 32'h0, 0, 32'h7777_1111, -1, lat, rd, err, viol, rdy, sa, sw, swe);
        exp_rdata = 32'h7777_1111;
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b ready_in_done: got %b want 1", rdy); end
        n_checks++; if (lat !== 1 || rd !== exp_rdata || viol !== 0 || sa !== 32'h2000) begin
            n_fail++; $display("FAIL b2b second: got lat %0d rdata %h viol %0d addr %h want 1 %h 0 00002000", lat, rd, viol, sa, exp_rdata); end
        step();
    endtask

    task automatic test_wrong_ack();
        int lat, viol; logic [31:0] rd, sa, sw; logic err, rdy, swe;
        run_txn(1'b0, 32'h0000_0400, 32'h0, 2, 32'h5555_AAAA, 0, lat, rd, err, viol, rdy, sa, sw, swe);
        exp_rdata = 32'h5555_AAAA;
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wrong_ack latency: got %0d want 3", lat); end
        n_checks++; if (rd !== exp_rdata || viol !== 0) begin n_fail++; $display("FAIL wrong_ack data: got %h viol %0d want %h 0", rd, viol, exp_rdata); end
        step();
    endtask

    task automatic test_idle_ack();
        s0_ack = 1'b1; s1_ack = 1'b1; s0_rdata = 32'h1111_2222; s1_rdata = 32'h3333_4444;
        step();
        s0_ack = 1'b0; s1_ack = 1'b0;
        n_checks++;
        if (m_done !== 1'b0 || m_ready !== 1'b1 || m_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL idle_ack: got done %b ready %b rdata %h want 0 1 %h", m_done, m_ready, m_rdata, exp_rdata);
        end
        step();
        n_checks++;
        if (m_done !== 1'b0 || s0_req !== 1'b0 || s1_req !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack_late: got done %b reqs %b%b want 0 00", m_done, s0_req, s1_req);
        end
    endtask

    task automatic test_random();
        int lat, viol, ack_lat, stray, gap;
        logic [31:0] rd, sa, sw, addr, wdata, adata;
        logic err, rdy, swe, we, done_ok;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3))
                0:       addr = {20'hFFFFF, 12'($urandom)};
                1:       addr = 32'hFFFF_E000 | 32'($urandom_range(4095));
                default: addr = $urandom;
            endcase
            we      = 1'($urandom_range(1));
            wdata   = $urandom;
            adata   = $urandom;
            ack_lat = $urandom_range(5);
            stray   = int'($urandom_range(ack_lat + 1)) - 1;
            run_txn(we, addr, wdata, ack_lat, adata, stray, lat, rd, err, viol, rdy, sa, sw, swe);
            if (!we) exp_rdata = adata;
            n_checks++;
            if (lat !== ack_lat + 1 || rd !== exp_rdata || err !== 1'b0) begin
                n_fail++; $display("FAIL random[%0d] result: got lat %0d rdata %h err %b want %0d %h 0",
                                   i, lat, rd, err, ack_lat + 1, exp_rdata);
            end
            n_checks++;
            if (rdy !== 1'b1 || viol !== 0 || sa !== addr || sw !== wdata || swe !== we) begin
                n_fail++; $display("FAIL random[%0d] bus: got rdy %b viol %0d addr %h wdata %h we %b want 1 0 %h %h %b",
                                   i, rdy, viol, sa, sw, swe, addr, wdata, we);
            end
            gap = $urandom_range(2);
            done_ok = 1'b1;
            for (int g = 0; g < gap; g++) begin
                step();
                if (m_done !== 1'b0 || m_rdata !== exp_rdata) done_ok = 1'b0;
            end
            if (gap > 0) begin
                n_checks++;
                if (!done_ok) begin n_fail++; $display("FAIL random[%0d] idle_hold: got done %b rdata %h want 0 %h", i, m_done, m_rdata, exp_rdata); end
            end
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        logic quiet;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0020; m_wdata = 32'h0;
        step();
        m_req = 1'b0;
        n_checks++;
        if (s0_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid busy_req: got %b want 1", s0_req); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (s0_req !== 1'b0 || m_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid async: got req %b ready %b want 0 1", s0_req, m_ready);
        end
        step();
        s0_ack = 1'b1;
        step();
        s0_ack = 1'b0;
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (m_done !== 1'b0 || m_ready !== 1'b1 || s0_req !== 1'b0 || m_rdata !== exp_rdata) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++; $display("FAIL rst_mid after: got done %b ready %b req %b rdata %h want 0 1 0 %h",
                               m_done, m_ready, s0_req, m_rdata, exp_rdata);
        end
    endtask

`ifdef DEMUX_TIMEOUT_EN
    task automatic test_timeout();
        int lat, viol; logic [31:0] rd, sa, sw; logic err, rdy, swe;
        run_txn(1'b0, 32'h0000_0100, 32'h0, -1, 32'h0, -1, lat, rd, err, viol, rdy, sa, sw, swe);
        exp_rdata = 32'hDEAD_BEEF;
        n_checks++;
        if (lat !== 16 || err !== 1'b1 || rd !== exp_rdata || viol !== 0) begin
            n_fail++; $display("FAIL timeout expire: got lat %0d err %b rdata %h viol %0d want 16 1 %h 0", lat, err, rd, viol, exp_rdata);
        end
        step();
        n_checks++;
        if (m_done !== 1'b0 || m_err !== 1'b0) begin n_fail++; $display("FAIL timeout pulse: got done %b err %b want 0 0", m_done, m_err); end
        run_txn(1'b0, 32'hFFFF_F010, 32'h0, 15, 32'h600D_D474, -1, lat, rd, err, viol, rdy, sa, sw, swe);
        exp_rdata = 32'h600D_D474;
        n_checks++;
        if (lat !== 16 || err !== 1'b0 || rd !== exp_rdata || viol !== 0) begin
            n_fail++; $display("FAIL timeout ack_wins: got lat %0d err %b rdata %h viol %0d want 16 0 %h 0", lat, err, rd, viol, exp_rdata);
        end
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_s0();
        test_write_s1();
        test_back_to_back();
        test_wrong_ack();
        test_idle_ack();
        test_random();
`ifdef DEMUX_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
